sram_hs: RTL and testbench

SRAM_HS -- requirements
Module: sram_hs

---
 rtl/sram_hs.sv | 217 +++++++++++++++++++++
 tb/tb_sram_hs.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_hs.sv
// sram_hs: single-port SRAM behind a start/done handshake with fixed latency.
// A request is captured in IDLE, waits in WAIT, then commits the write or
// loads the read data on the edge entering DONE. That edge is the LATENCY-th
// edge, counting the accepting edge as the first.
// Optional feature macro: SRAM_HS_PARITY_EN stores one even-parity bit per byte
// and reports mismatches on perr during done of a read.
module sram_hs #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                write,
  input  logic [ADDR_W-1:0]   ma,
  input  logic [DATA_W-1:0]   md,
  input  logic [DATA_W/8-1:0] be,
  input  logic                par_flip,
  output logic [DATA_W-1:0]   rd,
  output logic                done,
  output logic                busy,
  output logic                err,
  output logic                perr
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_wait = 2'd1,
    st_done = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                go_done_s;

  logic                wr_r;
  logic [ADDR_W-1:0]   ma_r;
  logic [DATA_W-1:0]   md_r;
  logic [NB-1:0]       be_r;

  logic                op_wr_s;
  logic [ADDR_W-1:0]   op_ma_s;
  logic [DATA_W-1:0]   op_md_s;
  logic [NB-1:0]       op_be_s;

  logic [DATA_W-1:0]   rd_r;
  logic                done_r, busy_r, err_r, perr_r;

  logic [DATA_W-1:0]   mem_r [DEPTH];

`ifdef SRAM_HS_PARITY_EN
  logic                pf_r;
  logic                op_pf_s;
  logic [NB-1:0]       par_r [DEPTH];

  // Even parity of one byte: the stored bit makes byte+bit XOR to zero.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

  // True when any byte of a word disagrees with its stored parity bit.
  function automatic logic par_bad(input logic [DATA_W-1:0] d, input logic [NB-1:0] p);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NB; i++) begin
      bad = bad | (byte_par(d[8*i +: 8]) ^ p[i]);
    end
    return bad;
  endfunction
`else
  logic                unused_pf_s;
  assign unused_pf_s = par_flip;
`endif

  // Next-state and counter logic; a start while reset is held is never accepted.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      st_idle: begin
        if (start && !reset) begin
          cnt_s = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_s = st_done;
          end else begin
            state_s = st_wait;
          end
        end else begin
          cnt_s = 4'd0;
        end
      end
      st_wait: begin
        // The edge that brings the counter to zero is the edge entering DONE.
        if (cnt_r <= 4'd1) begin
          state_s = st_done;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      st_done: begin
        state_s = st_idle;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = st_idle;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Marks the edge that enters DONE, where the operation takes effect.
  always_comb begin
    go_done_s = (state_s == st_done) && (state_r != st_done);
  end

  // Operation fields: live inputs on the accepting edge (LATENCY=1), captured copies after.
  always_comb begin
    if (state_r == st_idle) begin
      op_wr_s = write;
      op_ma_s = ma;
      op_md_s = md;
      op_be_s = be;
`ifdef SRAM_HS_PARITY_EN
      op_pf_s = par_flip;
`endif
    end else begin
      op_wr_s = wr_r;
      op_ma_s = ma_r;
      op_md_s = md_r;
      op_be_s = be_r;
`ifdef SRAM_HS_PARITY_EN
      op_pf_s = pf_r;
`endif
    end
  end

  // State register and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= st_idle;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Capture the request on the accepting edge so inputs may change afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_r <= 1'b0;
      ma_r <= '0;
      md_r <= '0;
      be_r <= '0;
`ifdef SRAM_HS_PARITY_EN
      pf_r <= 1'b0;
`endif
    end else if (state_r == st_idle && start) begin
      wr_r <= write;
      ma_r <= ma;
      md_r <= md;
      be_r <= be;
`ifdef SRAM_HS_PARITY_EN
      pf_r <= par_flip;
`endif
    end
  end

  // Registered handshake outputs, read data and parity error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_r   <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
      err_r  <= 1'b0;
      perr_r <= 1'b0;
    end else begin
      done_r <= (state_s == st_done);
      busy_r <= (state_s != st_idle);
      err_r  <= start && (state_r != st_idle);
      if (go_done_s && !op_wr_s) begin
        rd_r <= mem_r[op_ma_s];
      end
`ifdef SRAM_HS_PARITY_EN
      perr_r <= go_done_s && !op_wr_s && par_bad(mem_r[op_ma_s], par_r[op_ma_s]);
`else
      perr_r <= 1'b0;
`endif
    end
  end

  // Storage array (never reset): byte-masked commit on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (go_done_s && op_wr_s) begin
      for (int i = 0; i < NB; i++) begin
        if (op_be_s[i]) begin
          mem_r[op_ma_s][8*i +: 8] <= op_md_s[8*i +: 8];
`ifdef SRAM_HS_PARITY_EN
          par_r[op_ma_s][i] <= byte_par(op_md_s[8*i +: 8]) ^ op_pf_s;
`endif
        end
      end
    end
  end

  assign rd   = rd_r;
  assign done = done_r;
  assign busy = busy_r;
  assign err  = err_r;
  assign perr = perr_r;

endmodule

// File: tb/tb_sram_hs.sv
// Directed bench for sram_hs: default instance (32-bit, LATENCY=4) and a
// 64-bit, 16-word, LATENCY=1 instance sharing clock and reset.
module tb_sram_hs;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        a_start, a_write, a_pf;
  logic [7:0]  a_ma;
  logic [31:0] a_md;
  logic [3:0]  a_be;
  logic [31:0] a_rd;
  logic        a_done, a_busy, a_err, a_perr;

  // LATENCY=1, 64-bit instance
  logic        b_start, b_write, b_pf;
  logic [3:0]  b_ma;
  logic [63:0] b_md;
  logic [7:0]  b_be;
  logic [63:0] b_rd;
  logic        b_done, b_busy, b_err, b_perr;

  int tests = 0;
  int fails = 0;
  int lat;
  int bcnt;

`ifdef SRAM_HS_PARITY_EN
  localparam logic PEXP = 1'b1;
`else
  localparam logic PEXP = 1'b0;
`endif

  sram_hs u_a (
    .clk(clk), .reset(reset), .start(a_start), .write(a_write), .ma(a_ma),
    .md(a_md), .be(a_be), .par_flip(a_pf), .rd(a_rd), .done(a_done),
    .busy(a_busy), .err(a_err), .perr(a_perr)
  );

  sram_hs #(.DATA_W(64), .ADDR_W(4), .LATENCY(1)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .write(b_write), .ma(b_ma),
    .md(b_md), .be(b_be), .par_flip(b_pf), .rd(b_rd), .done(b_done),
    .busy(b_busy), .err(b_err), .perr(b_perr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance A; returns in the done cycle (or on timeout).
  // lat counts edges from the accepting edge (1) to the edge raising done.
  task automatic req_a(input logic w, input logic [7:0] ma, input logic [31:0] md,
                       input logic [3:0] be, input logic pf);
    @(negedge clk);
    if (a_busy) @(negedge clk);
    a_start = 1'b1; a_write = w; a_ma = ma; a_md = md; a_be = be; a_pf = pf;
    @(posedge clk); #1;
    a_start = 1'b0; a_write = ~w; a_ma = ~ma; a_md = ~md; a_be = ~be; a_pf = ~pf;
    lat  = 1;
    bcnt = a_busy ? 1 : 0;
    while (!a_done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (a_busy) bcnt++;
    end
  endtask

  task automatic req_b(input logic w, input logic [3:0] ma, input logic [63:0] md,
                       input logic [7:0] be);
    @(negedge clk);
    if (b_busy) @(negedge clk);
    b_start = 1'b1; b_write = w; b_ma = ma; b_md = md; b_be = be;
    @(posedge clk); #1;
    b_start = 1'b0; b_write = ~w; b_ma = ~ma; b_md = ~md; b_be = ~be;
    lat = 1;
    while (!b_done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_write = 1'b0; a_ma = 8'h00; a_md = 32'h0; a_be = 4'h0; a_pf = 1'b0;
    b_start = 1'b0; b_write = 1'b0; b_ma = 4'h0; b_md = 64'h0; b_be = 8'h00; b_pf = 1'b0;
    #12;
    chk("reset_a", {a_rd, a_done, a_busy, a_err, a_perr}, 64'h0);
    chk("reset_b", {b_done, b_busy, b_err, b_perr}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Basic write then read with default latency
    req_a(1'b1, 8'h02, 32'h0000_0005, 4'hF, 1'b0);
    chk("wr_latency", lat, 4);
    chk("wr_busy_cycles", bcnt, 4);
    chk("wr_keeps_rd", a_rd, 32'h0);
    @(posedge clk); #1;
    chk("post_done_low", {a_done, a_busy}, 64'h0);
    req_a(1'b0, 8'h02, 32'h0, 4'h0, 1'b0);
    chk("rd_latency", lat, 4);
    chk("rd_busy_cycles", bcnt, 4);
    chk("rd_data_02", a_rd, 32'h0000_0005);
    chk("rd_perr_02", a_perr, 1'b0);

    // Byte-enable merge
    req_a(1'b1, 8'h03, 32'h0000_0050, 4'hF, 1'b0);
    req_a(1'b1, 8'h03, 32'hAABB_CCDD, 4'h5, 1'b0);
    chk("rd_held_across_wr", a_rd, 32'h0000_0005);
    req_a(1'b0, 8'h03, 32'h0, 4'h0, 1'b0);
    chk("be_merge", a_rd, 32'h00BB_00DD);

    // be=0 completes but changes nothing
    req_a(1'b1, 8'h03, 32'hFFFF_FFFF, 4'h0, 1'b0);
    chk("be0_latency", lat, 4);
    req_a(1'b0, 8'h03, 32'h0, 4'h0, 1'b0);
    chk("be0_noop", a_rd, 32'h00BB_00DD);

    // Start during WAIT is rejected
    @(negedge clk);
    if (a_busy) @(negedge clk);
    a_start = 1'b1; a_write = 1'b1; a_ma = 8'h10; a_md = 32'hCAFE_F00D; a_be = 4'hF;
    @(posedge clk); #1;
    a_start = 1'b0;
    @(negedge clk);
    a_start = 1'b1; a_write = 1'b1; a_ma = 8'h10; a_md = 32'hDEAD_0000; a_be = 4'hF;
    @(posedge clk); #1;
    a_start = 1'b0; a_md = 32'h0;
    chk("wait_rej_err", a_err, 1'b1);
    chk("wait_rej_busy", a_busy, 1'b1);
    @(posedge clk); #1;
    chk("wait_rej_err_pulse", a_err, 1'b0);
    chk("wait_rej_no_early_done", a_done, 1'b0);
    @(posedge clk); #1;
    chk("wait_rej_orig_done", a_done, 1'b1);

    // Start in the done cycle is rejected too
    @(negedge clk);
    a_start = 1'b1; a_write = 1'b1; a_ma = 8'h02; a_md = 32'h0000_0099; a_be = 4'hF;
    @(posedge clk); #1;
    a_start = 1'b0;
    chk("done_rej_err", a_err, 1'b1);
    chk("done_rej_idle", a_busy, 1'b0);
    req_a(1'b0, 8'h10, 32'h0, 4'h0, 1'b0);
    chk("wait_rej_orig_data", a_rd, 32'hCAFE_F00D);
    req_a(1'b0, 8'h02, 32'h0, 4'h0, 1'b0);
    chk("done_rej_no_effect", a_rd, 32'h0000_0005);

    // Reset mid-write aborts the write; memory survives reset
    req_a(1'b1, 8'h20, 32'h1111_1111, 4'hF, 1'b0);
    @(negedge clk);
    if (a_busy) @(negedge clk);
    a_start = 1'b1; a_write = 1'b1; a_ma = 8'h20; a_md = 32'h1234_5678; a_be = 4'hF;
    @(posedge clk); #1;
    a_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {a_rd, a_done, a_busy, a_err, a_perr}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    req_a(1'b0, 8'h20, 32'h0, 4'h0, 1'b0);
    chk("after_reset_latency", lat, 4);
    chk("aborted_write", a_rd, 32'h1111_1111);

    // Parity injection
    req_a(1'b1, 8'h05, 32'h0102_0304, 4'hF, 1'b1);
    req_a(1'b0, 8'h05, 32'h0, 4'h0, 1'b0);
    chk("par_flip_data", a_rd, 32'h0102_0304);
    chk("par_flip_perr", a_perr, PEXP);
    @(posedge clk); #1;
    chk("perr_pulse", a_perr, 1'b0);
    req_a(1'b1, 8'h05, 32'h0102_0304, 4'hF, 1'b0);
    req_a(1'b0, 8'h05, 32'h0, 4'h0, 1'b0);
    chk("par_clean_perr", a_perr, 1'b0);

    // LATENCY=1, 64-bit instance
    req_b(1'b1, 4'hF, 64'h0123_4567_89AB_CDEF, 8'hFF);
    chk("b_wr_latency", lat, 1);
    chk("b_wr_keeps_rd", b_rd, 64'h0);
    req_b(1'b0, 4'hF, 64'h0, 8'h00);
    chk("b_rd_latency", lat, 1);
    chk("b_rd_data", b_rd, 64'h0123_4567_89AB_CDEF);
    req_b(1'b1, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    req_b(1'b0, 4'hF, 64'h0, 8'h00);
    chk("b_be_merge", b_rd, 64'h0123_4567_FFFF_FFFF);
    @(posedge clk); #1;
    chk("b_post_done_low", {b_done, b_busy, b_perr}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
